pipe_bus_arbiter: RTL and testbench



---
 rtl/pipe_bus_arbiter_pkg.sv | 27 ++
 rtl/arb_select.sv | 27 ++
 rtl/pipe_bus_arbiter.sv | 152 +++++++++++++++
 tb/tb_pipe_bus_arbiter.sv | 199 +++++++++++++++++++
 4 files changed

// File: rtl/pipe_bus_arbiter_pkg.sv
// Shared pipeline package "pipes": memory-bus widths, arbiter state encoding,
// the latched bus-request payload and the fixed instruction-fetch size code.
package pipes;

    localparam int unsigned ADDR_W = 64;
    localparam int unsigned DATA_W = 64;
    localparam int unsigned INSN_W = 32;
    localparam int unsigned SIZE_W = 3;
    localparam int unsigned STRB_W = 8;

    // Size code for a 4-byte instruction fetch
    localparam logic [SIZE_W-1:0] MSIZE_INSN = 3'd2;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        BUSY_D = 2'd1,
        BUSY_I = 2'd2
    } arb_state_t;

    typedef struct packed {
        logic [ADDR_W-1:0] addr;
        logic [SIZE_W-1:0] size;
        logic [STRB_W-1:0] strobe;
        logic [DATA_W-1:0] wdata;
    } arb_req_t;

endpackage

// File: rtl/arb_select.sv
// Combinational grant selection between the data and fetch requesters.
// Optional feature macro: ARB_ROUND_ROBIN_EN (ties go to the port not granted
// last); otherwise data has fixed priority over fetch.
// Ports:
//   d_valid, i_valid   - pending requests
//   last_grant         - 0 = data granted last, 1 = fetch granted last
//   grant_d, grant_i   - one-hot (or zero) grant
module arb_select (
    input  logic d_valid,
    input  logic i_valid,
    input  logic last_grant,
    output logic grant_d,
    output logic grant_i
);

`ifdef ARB_ROUND_ROBIN_EN
    // On a tie, favour whichever port did not win last time
    assign grant_d = d_valid & (~i_valid | last_grant);
    assign grant_i = i_valid & (~d_valid | ~last_grant);
`else
    logic w_unused;
    assign w_unused = last_grant;
    assign grant_d  = d_valid;
    assign grant_i  = i_valid & ~d_valid;
`endif

endmodule

// File: rtl/pipe_bus_arbiter.sv
// Two-to-one arbiter sharing the single memory bus between the fetch stage
// (instruction port) and the memory stage (data port). The winning request is
// latched into hold registers that alone drive the shared bus, and the bus
// response is routed back to the granted port in the same cycle.
// Optional feature macro: ARB_ROUND_ROBIN_EN (round-robin tie break in IDLE).
// Ports:
//   clk, reset                          - core clock, async active-high reset
//   d_valid/d_addr/d_size/d_strobe/d_wdata, d_ok/d_rdata - data port
//   i_valid/i_addr, i_ok/i_rdata        - fetch port
//   o_valid/o_is_write/o_addr/o_size/o_strobe/o_wdata, o_ok/o_rdata - shared bus
module pipe_bus_arbiter
    import pipes::*;
(
    input  logic              clk,
    input  logic              reset,
    input  logic              d_valid,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic [SIZE_W-1:0] d_size,
    input  logic [STRB_W-1:0] d_strobe,
    input  logic [DATA_W-1:0] d_wdata,
    output logic              d_ok,
    output logic [DATA_W-1:0] d_rdata,
    input  logic              i_valid,
    input  logic [ADDR_W-1:0] i_addr,
    output logic              i_ok,
    output logic [INSN_W-1:0] i_rdata,
    output logic              o_valid,
    output logic              o_is_write,
    output logic [ADDR_W-1:0] o_addr,
    output logic [SIZE_W-1:0] o_size,
    output logic [STRB_W-1:0] o_strobe,
    output logic [DATA_W-1:0] o_wdata,
    input  logic              o_ok,
    input  logic [DATA_W-1:0] o_rdata
);

    arb_state_t r_state;
    arb_state_t w_next;
    arb_req_t   r_req;
    logic       w_grant_d;
    logic       w_grant_i;
    logic       w_last_grant;
    logic       w_load_d;
    logic       w_load_i;

`ifdef ARB_ROUND_ROBIN_EN
    // Last-grant tracker: 0 = data, 1 = fetch; updated on every grant
    logic r_last_grant;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_last_grant <= 1'b0;
        end else if (w_load_d) begin
            r_last_grant <= 1'b0;
        end else if (w_load_i) begin
            r_last_grant <= 1'b1;
        end
    end

    assign w_last_grant = r_last_grant;
`else
    assign w_last_grant = 1'b0;
`endif

    arb_select u_arb_select (
        .d_valid    (d_valid),
        .i_valid    (i_valid),
        .last_grant (w_last_grant),
        .grant_d    (w_grant_d),
        .grant_i    (w_grant_i)
    );

    // State register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Next state: on completion hand over to the other port if it waits,
    // never regrant the port that just finished
    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE: begin
                if (w_grant_d) begin
                    w_next = BUSY_D;
                end else if (w_grant_i) begin
                    w_next = BUSY_I;
                end
            end
            BUSY_D: begin
                if (o_ok) begin
                    w_next = i_valid ? BUSY_I : IDLE;
                end
            end
            BUSY_I: begin
                if (o_ok) begin
                    w_next = d_valid ? BUSY_D : IDLE;
                end
            end
            default: w_next = IDLE;
        endcase
    end

    // A grant is any entry into a BUSY state from elsewhere
    assign w_load_d = (w_next == BUSY_D) && (r_state != BUSY_D);
    assign w_load_i = (w_next == BUSY_I) && (r_state != BUSY_I);

    // Hold registers: sampled at grant, stable for the whole transaction
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_req <= '0;
        end else if (w_load_d) begin
            r_req <= '{addr: d_addr, size: d_size, strobe: d_strobe, wdata: d_wdata};
        end else if (w_load_i) begin
            r_req <= '{addr: i_addr, size: MSIZE_INSN, strobe: '0, wdata: '0};
        end
    end

    // Outputs decoded from state; completion is forwarded only to the owner
    always_comb begin
        o_valid = 1'b0;
        d_ok    = 1'b0;
        i_ok    = 1'b0;
        case (r_state)
            BUSY_D: begin
                o_valid = 1'b1;
                d_ok    = o_ok;
            end
            BUSY_I: begin
                o_valid = 1'b1;
                i_ok    = o_ok;
            end
            default: begin
                o_valid = 1'b0;
            end
        endcase
    end

    assign o_addr     = r_req.addr;
    assign o_size     = r_req.size;
    assign o_strobe   = r_req.strobe;
    assign o_wdata    = r_req.wdata;
    assign o_is_write = |r_req.strobe;
    assign d_rdata    = o_rdata;
    // Pick the 32-bit word selected by address bit 2
    assign i_rdata    = r_req.addr[2] ? o_rdata[63:32] : o_rdata[31:0];

endmodule

// File: tb/tb_pipe_bus_arbiter.sv
// Directed self-checking bench for pipe_bus_arbiter: reset state, fetch-only,
// data write, contention with handover, early drop, o_ok while idle, and reset
// in the middle of a data transaction.
module tb_pipe_bus_arbiter;

    logic        clk;
    logic        reset;
    logic        d_valid;
    logic [63:0] d_addr;
    logic [2:0]  d_size;
    logic [7:0]  d_strobe;
    logic [63:0] d_wdata;
    logic        d_ok;
    logic [63:0] d_rdata;
    logic        i_valid;
    logic [63:0] i_addr;
    logic        i_ok;
    logic [31:0] i_rdata;
    logic        o_valid;
    logic        o_is_write;
    logic [63:0] o_addr;
    logic [2:0]  o_size;
    logic [7:0]  o_strobe;
    logic [63:0] o_wdata;
    logic        o_ok;
    logic [63:0] o_rdata;

    int n_checks;
    int n_errors;

`ifdef ARB_ROUND_ROBIN_EN
    localparam bit RR = 1'b1;
`else
    localparam bit RR = 1'b0;
`endif

    pipe_bus_arbiter dut (
        .clk        (clk),
        .reset      (reset),
        .d_valid    (d_valid),
        .d_addr     (d_addr),
        .d_size     (d_size),
        .d_strobe   (d_strobe),
        .d_wdata    (d_wdata),
        .d_ok       (d_ok),
        .d_rdata    (d_rdata),
        .i_valid    (i_valid),
        .i_addr     (i_addr),
        .i_ok       (i_ok),
        .i_rdata    (i_rdata),
        .o_valid    (o_valid),
        .o_is_write (o_is_write),
        .o_addr     (o_addr),
        .o_size     (o_size),
        .o_strobe   (o_strobe),
        .o_wdata    (o_wdata),
        .o_ok       (o_ok),
        .o_rdata    (o_rdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(negedge clk);
    endtask

    initial begin
        n_checks = 0;
        n_errors = 0;
        reset    = 1'b1;
        d_valid  = 1'b0;
        d_addr   = '0;
        d_size   = '0;
        d_strobe = '0;
        d_wdata  = '0;
        i_valid  = 1'b0;
        i_addr   = '0;
        o_ok     = 1'b0;
        o_rdata  = '0;

        // Reset state
        tick(); #1;
        check("rst_valid",  64'(o_valid),  64'd0);
        check("rst_addr",   o_addr,        64'd0);
        check("rst_size",   64'(o_size),   64'd0);
        check("rst_strobe", 64'(o_strobe), 64'd0);
        check("rst_wdata",  o_wdata,       64'd0);
        tick(); reset = 1'b0;

        // Fetch only, response three cycles after grant
        tick(); i_valid = 1'b1; i_addr = 64'h0000_0000_8000_0004;
        tick(); #1;
        check("f_valid", 64'(o_valid),    64'd1);
        check("f_addr",  o_addr,          64'h0000_0000_8000_0004);
        check("f_size",  64'(o_size),     64'd2);
        check("f_wr",    64'(o_is_write), 64'd0);
        check("f_ok_lo", 64'(i_ok),       64'd0);
        tick();
        tick();
        tick(); o_ok = 1'b1; o_rdata = 64'h1111_2222_3333_4444; #1;
        check("f_ok",    64'(i_ok),    64'd1);
        check("f_rdata", 64'(i_rdata), 64'h1111_2222);
        check("f_dok",   64'(d_ok),    64'd0);
        tick(); o_ok = 1'b0; i_valid = 1'b0; #1;
        check("f_idle",  64'(o_valid), 64'd0);
        check("f_ok_end", 64'(i_ok),   64'd0);

        // Data write, fields held until o_ok
        tick(); d_valid = 1'b1; d_addr = 64'h1000; d_size = 3'd3;
        d_strobe = 8'hF0; d_wdata = 64'hDEAD_BEEF_0000_0000;
        tick(); #1;
        check("w_valid",  64'(o_valid),    64'd1);
        check("w_wr",     64'(o_is_write), 64'd1);
        check("w_addr",   o_addr,          64'h1000);
        check("w_size",   64'(o_size),     64'd3);
        check("w_strobe", 64'(o_strobe),   64'hF0);
        check("w_wdata",  o_wdata,         64'hDEAD_BEEF_0000_0000);
        tick(); #1;
        check("w_hold",   o_wdata,         64'hDEAD_BEEF_0000_0000);
        check("w_ok_lo",  64'(d_ok),       64'd0);
        tick(); o_ok = 1'b1; o_rdata = 64'h0123_4567_89AB_CDEF; #1;
        check("w_ok",     64'(d_ok),       64'd1);
        check("w_rdata",  d_rdata,         64'h0123_4567_89AB_CDEF);
        check("w_iok",    64'(i_ok),       64'd0);
        tick(); o_ok = 1'b0; d_valid = 1'b0; d_strobe = 8'h00; #1;
        check("w_idle",   64'(o_valid),    64'd0);
        check("w_ok_end", 64'(d_ok),       64'd0);

        // Contention: both ports continuously valid, grants alternate
        tick(); d_valid = 1'b1; d_addr = 64'h2000; d_size = 3'd3; d_strobe = 8'h00;
        d_wdata = '0; i_valid = 1'b1; i_addr = 64'h3000;
        tick(); #1;
        check("c1_addr", o_addr, RR ? 64'h3000 : 64'h2000);
        check("c1_wr",   64'(o_is_write), 64'd0);
        o_ok = 1'b1; o_rdata = 64'hAAAA_BBBB_CCCC_DDDD; #1;
        check("c1_dok",  64'(d_ok), RR ? 64'd0 : 64'd1);
        check("c1_iok",  64'(i_ok), RR ? 64'd1 : 64'd0);
        tick(); o_ok = 1'b0; #1;
        check("c2_valid", 64'(o_valid), 64'd1);
        check("c2_addr",  o_addr, RR ? 64'h2000 : 64'h3000);
        check("c2_size",  64'(o_size), RR ? 64'd3 : 64'd2);
        o_ok = 1'b1; #1;
        check("c2_iok",   64'(i_ok), RR ? 64'd0 : 64'd1);
        check("c2_irdata", 64'(i_rdata), 64'hCCCC_DDDD);
        tick(); o_ok = 1'b0; #1;
        check("c3_valid", 64'(o_valid), 64'd1);
        check("c3_addr",  o_addr, RR ? 64'h3000 : 64'h2000);
        o_ok = 1'b1; d_valid = 1'b0; i_valid = 1'b0;
        tick(); o_ok = 1'b0; #1;
        check("c_idle",   64'(o_valid), 64'd0);

        // Early drop: fetch withdraws after grant, transaction still completes
        tick(); i_valid = 1'b1; i_addr = 64'h4000;
        tick(); i_valid = 1'b0; #1;
        check("e_valid1", 64'(o_valid), 64'd1);
        tick(); #1;
        check("e_valid2", 64'(o_valid), 64'd1);
        check("e_addr",   o_addr, 64'h4000);
        o_ok = 1'b1; o_rdata = 64'h5555_6666_7777_8888; #1;
        check("e_ok",     64'(i_ok), 64'd1);
        check("e_rdata",  64'(i_rdata), 64'h7777_8888);
        tick(); o_ok = 1'b0; #1;
        check("e_idle",   64'(o_valid), 64'd0);

        // o_ok while idle is ignored
        o_ok = 1'b1; #1;
        check("n_dok", 64'(d_ok), 64'd0);
        check("n_iok", 64'(i_ok), 64'd0);
        tick(); o_ok = 1'b0; #1;
        check("n_idle", 64'(o_valid), 64'd0);

        // Reset in the middle of a data transaction
        tick(); d_valid = 1'b1; d_addr = 64'h5000; d_strobe = 8'hFF;
        d_wdata = 64'h1234_5678_9ABC_DEF0;
        tick(); #1;
        check("r_busy", 64'(o_valid), 64'd1);
        o_ok = 1'b1; reset = 1'b1; #1;
        check("r_drop", 64'(o_valid), 64'd0);
        check("r_dok",  64'(d_ok),    64'd0);
        check("r_addr", o_addr,       64'd0);
        tick(); reset = 1'b0; o_ok = 1'b0; d_valid = 1'b0; #1;
        check("r_idle", 64'(o_valid), 64'd0);
        tick(); #1;
        check("r_idle2", 64'(o_valid), 64'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
